// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock time/alarm entry logic:
// key codes, entry FSM states, BCD time payload and timeout length.
package aclk_pkg;

    localparam int unsigned KEY_W           = 4;
    localparam int unsigned DIGIT_W         = 4;
    localparam int unsigned BUF_W           = 16;
    localparam int unsigned CNT_W           = 3;
    localparam int unsigned IDLE_W          = 4;
    localparam int unsigned NUM_DIGITS      = 4;
    localparam int unsigned TIMEOUT_SECONDS = 10;

    localparam logic [KEY_W-1:0] KEY_SET_TIME  = 4'hA;
    localparam logic [KEY_W-1:0] KEY_SET_ALARM = 4'hB;
    localparam logic [KEY_W-1:0] KEY_CANCEL    = 4'hC;
    localparam logic [KEY_W-1:0] KEY_ENTER     = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOAD    = 2'd3
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] ms_hr;
        logic [DIGIT_W-1:0] ls_hr;
        logic [DIGIT_W-1:0] ms_min;
        logic [DIGIT_W-1:0] ls_min;
    } bcd_time_t;

    function automatic logic is_digit(input logic [KEY_W-1:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/aclk_bcd_time_check.sv
// Combinational validity check of a 24-hour HH:MM value held as four BCD digits.
module aclk_bcd_time_check
    import aclk_pkg::*;
(
    input  logic [BUF_W-1:0] time_bcd,
    output logic             valid_c
);

    bcd_time_t t;

    assign t = bcd_time_t'(time_bcd);

    always_comb begin
        valid_c = (t.ms_hr  <= 4'd2) &&
                  (t.ls_hr  <= 4'd9) &&
                  ((t.ms_hr != 4'd2) || (t.ls_hr <= 4'd3)) &&
                  (t.ms_min <= 4'd5) &&
                  (t.ls_min <= 4'd9);
    end

endmodule

// File: rtl/aclk_time_entry.sv
// Keypad entry of a new current time or alarm time: collects four BCD digits,
// validates them and issues a one-cycle load toward the time counter or alarm register.
module aclk_time_entry
    import aclk_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key_code,
    input  logic               one_second,
    output logic [DIGIT_W-1:0] new_current_time_ms_hr,
    output logic [DIGIT_W-1:0] new_current_time_ls_hr,
    output logic [DIGIT_W-1:0] new_current_time_ms_min,
    output logic [DIGIT_W-1:0] new_current_time_ls_min,
    output logic               load_new_c,
    output logic [DIGIT_W-1:0] new_alarm_ms_hr,
    output logic [DIGIT_W-1:0] new_alarm_ls_hr,
    output logic [DIGIT_W-1:0] new_alarm_ms_min,
    output logic [DIGIT_W-1:0] new_alarm_ls_min,
    output logic               load_new_a,
    output logic [BUF_W-1:0]   key_buffer,
    output logic               entry_active,
    output logic               entry_error
);

    state_t              state_q, state_n;
    bcd_time_t           buf_q, buf_n;
    bcd_time_t           time_q, time_n;
    bcd_time_t           alarm_q, alarm_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [IDLE_W-1:0]   idle_q, idle_n;
    logic                tgt_q, tgt_n;
    logic                load_c_n, load_a_n, err_n, active_n;
    logic                buf_valid_c;

    aclk_bcd_time_check u_check (
        .time_bcd (buf_q),
        .valid_c  (buf_valid_c)
    );

    // State and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            buf_q        <= '0;
            time_q       <= '0;
            alarm_q      <= '0;
            cnt_q        <= '0;
            idle_q       <= '0;
            tgt_q        <= 1'b0;
            load_new_c   <= 1'b0;
            load_new_a   <= 1'b0;
            entry_error  <= 1'b0;
            entry_active <= 1'b0;
        end else begin
            state_q      <= state_n;
            buf_q        <= buf_n;
            time_q       <= time_n;
            alarm_q      <= alarm_n;
            cnt_q        <= cnt_n;
            idle_q       <= idle_n;
            tgt_q        <= tgt_n;
            load_new_c   <= load_c_n;
            load_new_a   <= load_a_n;
            entry_error  <= err_n;
            entry_active <= active_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state_q;
        buf_n    = buf_q;
        time_n   = time_q;
        alarm_n  = alarm_q;
        cnt_n    = cnt_q;
        idle_n   = idle_q;
        tgt_n    = tgt_q;
        load_c_n = 1'b0;
        load_a_n = 1'b0;
        err_n    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                idle_n = '0;
                if (key_valid && (key_code == KEY_SET_TIME || key_code == KEY_SET_ALARM)) begin
                    buf_n   = '0;
                    cnt_n   = '0;
                    tgt_n   = (key_code == KEY_SET_ALARM);
                    state_n = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                // A key always wins over a coincident one_second strobe.
                if (key_valid) begin
                    idle_n = '0;
                    if (is_digit(key_code)) begin
                        if (cnt_q < CNT_W'(NUM_DIGITS)) begin
                            buf_n = bcd_time_t'({buf_q[BUF_W-DIGIT_W-1:0], key_code});
                            cnt_n = CNT_W'(cnt_q + 1'b1);
                        end
                    end else if (key_code == KEY_SET_TIME || key_code == KEY_SET_ALARM) begin
                        buf_n = '0;
                        cnt_n = '0;
                        tgt_n = (key_code == KEY_SET_ALARM);
                    end else if (key_code == KEY_CANCEL) begin
                        state_n = ST_IDLE;
                    end else if (key_code == KEY_ENTER) begin
                        if (cnt_q == CNT_W'(NUM_DIGITS)) begin
                            state_n = ST_CHECK;
                        end else begin
                            err_n   = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end
                end else if (one_second) begin
                    if (idle_q == IDLE_W'(TIMEOUT_SECONDS - 1)) begin
                        idle_n  = '0;
                        state_n = ST_IDLE;
                    end else begin
                        idle_n = IDLE_W'(idle_q + 1'b1);
                    end
                end
            end

            ST_CHECK: begin
                if (key_valid && key_code == KEY_CANCEL) begin
                    state_n = ST_IDLE;
                end else if (buf_valid_c) begin
                    state_n = ST_LOAD;
                end else begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end

            ST_LOAD: begin
                if (tgt_q) begin
                    alarm_n  = buf_q;
                    load_a_n = 1'b1;
                end else begin
                    time_n   = buf_q;
                    load_c_n = 1'b1;
                end
                state_n = ST_IDLE;
            end

            default: state_n = ST_IDLE;
        endcase

        active_n = (state_n == ST_COLLECT) || (state_n == ST_CHECK);
    end

    assign key_buffer              = buf_q;
    assign new_current_time_ms_hr  = time_q.ms_hr;
    assign new_current_time_ls_hr  = time_q.ls_hr;
    assign new_current_time_ms_min = time_q.ms_min;
    assign new_current_time_ls_min = time_q.ls_min;
    assign new_alarm_ms_hr         = alarm_q.ms_hr;
    assign new_alarm_ls_hr         = alarm_q.ls_hr;
    assign new_alarm_ms_min        = alarm_q.ms_min;
    assign new_alarm_ls_min        = alarm_q.ls_min;

endmodule
